// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
//
// Load/store unit sitting between the core datapath and the word-only data
// memory. One request is accepted at a time and turned into memory cycles:
// a single read for loads, a single write for word stores, and a
// read-modify-write for byte/half stores. Completion is signalled by a
// one-cycle response pulse carrying the aligned, extended load result.
//
// Parameters
//   ERR_ON_MISALIGN  1: misaligned half/word requests fail without touching
//                       memory; 0: low address bits are forced to alignment.
//   BIG_ENDIAN       1: byte offset 0 is bits [31:24]; 0: bits [7:0].
//
// Ports
//   clk, rst_lsu          clock (rising edge), synchronous active-high reset
//   req_valid/req_ready   request handshake; ready only while idle
//   req_write             1 = store, 0 = load
//   req_size              00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned          zero-extend sub-word load results
//   req_addr, req_wdata   byte address and store data (low bits used)
//   resp_valid            one-cycle completion pulse
//   resp_rdata, resp_err  load result / error flag, valid with resp_valid
//   dm_addr               word-aligned memory address, 0 when idle
//   dm_write_data         word to write to memory
//   ctrl_dataMem_Write    memory write enable
//   ctrl_dataMem2reg      memory read enable
//   dm_read_data          combinational read data from memory
// ---------------------------------------------------------------------------
module lsu_ctrl #(
    parameter bit ERR_ON_MISALIGN = 1'b1,
    parameter bit BIG_ENDIAN      = 1'b1
) (
    input  logic        clk,
    input  logic        rst_lsu,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_write_data,
    output logic        ctrl_dataMem_Write,
    output logic        ctrl_dataMem2reg,
    input  logic [31:0] dm_read_data
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rword_q, rword_d;
    logic [1:0]  size_q, size_d;
    logic        unsigned_q, unsigned_d;
    logic        write_q, write_d;
    logic        err_q, err_d;

    logic        accept;
    logic        reqErr;
    logic [4:0]  laneShift;
    logic [31:0] laneMask;
    logic [31:0] extracted;
    logic [31:0] mergedWord;
    logic [31:0] loadResult;

    assign accept = req_valid && req_ready;

    // A request is rejected for an illegal size, or for misalignment when
    // misalignment is configured to be an error.
    assign reqErr = (req_size == 2'b11) ||
                    (ERR_ON_MISALIGN &&
                     (((req_size == 2'b01) && req_addr[0]) ||
                      ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))));

    // State and request registers; reset takes priority, so a request
    // presented during reset is never latched.
    always_ff @(posedge clk) begin
        if (rst_lsu) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rword_q    <= '0;
            size_q     <= '0;
            unsigned_q <= 1'b0;
            write_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rword_q    <= rword_d;
            size_q     <= size_d;
            unsigned_q <= unsigned_d;
            write_q    <= write_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic. On accept the request is latched (with the address
    // pre-aligned when misalignment is tolerated) and the access type picks
    // the first memory state. Both read states capture the memory word.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rword_d    = rword_q;
        size_d     = size_q;
        unsigned_d = unsigned_q;
        write_d    = write_q;
        err_d      = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    size_d     = req_size;
                    unsigned_d = req_unsigned;
                    write_d    = req_write;
                    err_d      = reqErr;
                    if (!ERR_ON_MISALIGN) begin
                        if (req_size == 2'b10) begin
                            addr_d[1:0] = 2'b00;
                        end else if (req_size == 2'b01) begin
                            addr_d[0] = 1'b0;
                        end
                    end
                    if (reqErr) begin
                        state_d = RESP;
                    end else if (!req_write) begin
                        state_d = RD;
                    end else if (req_size == 2'b10) begin
                        state_d = WR;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD: begin
                rword_d = dm_read_data;
                state_d = RESP;
            end
            RMW_RD: begin
                rword_d = dm_read_data;
                state_d = WR;
            end
            WR: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lane selection shared by load extraction and store merging. A word
    // access uses a full mask with no shift, so both paths reduce to the
    // whole word.
    always_comb begin
        laneShift = 5'd0;
        laneMask  = 32'hFFFF_FFFF;
        if (size_q == 2'b00) begin
            laneShift = BIG_ENDIAN ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000};
            laneMask  = 32'h0000_00FF << laneShift;
        end else if (size_q == 2'b01) begin
            laneShift = BIG_ENDIAN ? {~addr_q[1], 4'b0000} : {addr_q[1], 4'b0000};
            laneMask  = 32'h0000_FFFF << laneShift;
        end
        extracted  = (rword_q & laneMask) >> laneShift;
        mergedWord = (rword_q & ~laneMask) | ((wdata_q << laneShift) & laneMask);
        case (size_q)
            2'b00:   loadResult = unsigned_q ? {24'd0, extracted[7:0]}
                                             : {{24{extracted[7]}}, extracted[7:0]};
            2'b01:   loadResult = unsigned_q ? {16'd0, extracted[15:0]}
                                             : {{16{extracted[15]}}, extracted[15:0]};
            default: loadResult = extracted;
        endcase
    end

    // Output decode. The write enable is gated by reset so a reset landing
    // in WR (e.g. mid read-modify-write) leaves memory untouched.
    always_comb begin
        req_ready          = (state_q == IDLE);
        resp_valid         = 1'b0;
        resp_rdata         = '0;
        resp_err           = 1'b0;
        dm_addr            = '0;
        dm_write_data      = '0;
        ctrl_dataMem_Write = 1'b0;
        ctrl_dataMem2reg   = 1'b0;
        case (state_q)
            RD, RMW_RD: begin
                dm_addr          = {addr_q[31:2], 2'b00};
                ctrl_dataMem2reg = 1'b1;
            end
            WR: begin
                dm_addr            = {addr_q[31:2], 2'b00};
                dm_write_data      = (size_q == 2'b10) ? wdata_q : mergedWord;
                ctrl_dataMem_Write = !rst_lsu;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                resp_rdata = (!write_q && !err_q) ? loadResult : 32'd0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
//
// Bench for lsu_ctrl. A behavioural word memory sits on the dm_* port.
// Each request pushes its expected response (data, error, latency) into a
// queue; a negedge monitor pops and compares whenever resp_valid pulses.
// A second instance with misalignment tolerated covers the aligning path.
// ---------------------------------------------------------------------------
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_lsu;
   logic        preload;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] dm_addr;
   logic [31:0] dm_write_data;
   logic        ctrl_dataMem_Write;
   logic        ctrl_dataMem2reg;
   logic [31:0] dm_read_data;

   logic        reqValid2;
   logic        reqReady2;
   logic [1:0]  reqSize2;
   logic [31:0] reqAddr2;
   logic        respValid2;
   logic [31:0] respRdata2;
   logic        respErr2;
   logic [31:0] dmAddr2;
   logic [31:0] dmWriteData2;
   logic        memWrite2;
   logic        memRead2;
   logic [31:0] dmReadData2;

   logic [31:0] mem [0:255];

   int cyc = 0;
   int testsRun = 0;
   int testsFailed = 0;
   int wrPulses = 0;
   int rdPulses = 0;

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          acceptCyc;
   } expect_t;

   expect_t sbQ[$];
   expect_t monItem;

   lsu_ctrl dut (
      .clk                (clk),
      .rst_lsu            (rst_lsu),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_write          (req_write),
      .req_size           (req_size),
      .req_unsigned       (req_unsigned),
      .req_addr           (req_addr),
      .req_wdata          (req_wdata),
      .resp_valid         (resp_valid),
      .resp_rdata         (resp_rdata),
      .resp_err           (resp_err),
      .dm_addr            (dm_addr),
      .dm_write_data      (dm_write_data),
      .ctrl_dataMem_Write (ctrl_dataMem_Write),
      .ctrl_dataMem2reg   (ctrl_dataMem2reg),
      .dm_read_data       (dm_read_data)
   );

   lsu_ctrl #(.ERR_ON_MISALIGN(1'b0), .BIG_ENDIAN(1'b1)) dutAlign (
      .clk                (clk),
      .rst_lsu            (rst_lsu),
      .req_valid          (reqValid2),
      .req_ready          (reqReady2),
      .req_write          (1'b0),
      .req_size           (reqSize2),
      .req_unsigned       (1'b0),
      .req_addr           (reqAddr2),
      .req_wdata          (32'd0),
      .resp_valid         (respValid2),
      .resp_rdata         (respRdata2),
      .resp_err           (respErr2),
      .dm_addr            (dmAddr2),
      .dm_write_data      (dmWriteData2),
      .ctrl_dataMem_Write (memWrite2),
      .ctrl_dataMem2reg   (memRead2),
      .dm_read_data       (dmReadData2)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Word memory: preloaded with the test patterns, written only by the
   // main instance; both instances read combinationally.
   always @(posedge clk) begin
      if (preload) begin
         mem[4]  <= 32'h0000_0000;
         mem[8]  <= 32'h80FF_7F01;
         mem[12] <= 32'h1122_3344;
         mem[16] <= 32'hCAFE_F00D;
         mem[20] <= 32'h5566_7788;
         mem[24] <= 32'h0000_0000;
      end else if (ctrl_dataMem_Write) begin
         mem[dm_addr[9:2]] <= dm_write_data;
      end
   end

   assign dm_read_data = mem[dm_addr[9:2]];
   assign dmReadData2  = mem[dmAddr2[9:2]];

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Response monitor: every resp_valid pulse must match the oldest
   // outstanding expectation, including its latency from acceptance.
   always @(negedge clk) begin
      if (ctrl_dataMem_Write) wrPulses++;
      if (ctrl_dataMem2reg) rdPulses++;
      if (resp_valid) begin
         if (sbQ.size() == 0) begin
            checkOutput("spuriousResp", 32'd1, 32'd0);
         end else begin
            monItem = sbQ.pop_front();
            checkOutput({monItem.tag, "Data"}, resp_rdata, monItem.rdata);
            checkOutput({monItem.tag, "Err"}, {31'd0, resp_err}, {31'd0, monItem.err});
            checkOutput({monItem.tag, "Lat"}, cyc - monItem.acceptCyc, monItem.lat);
         end
      end
   end

   // Waits for req_ready, presents one request, records its expected
   // response and returns #1 after the accepting edge. With hold set,
   // req_valid is left high for the next call.
   task automatic applyStimulus(input string tag, input logic wr, input logic [1:0] sz,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] expRdata,
                                input logic expErr, input int lat, input logic hold);
      expect_t e;
      bit ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) begin
            ready = 1'b1;
            break;
         end
      end
      if (!ready) begin
         checkOutput({tag, "ReadyTimeout"}, 32'd0, 32'd1);
         req_valid = 1'b0;
         return;
      end
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      e.tag        = tag;
      e.rdata      = expRdata;
      e.err        = expErr;
      e.lat        = lat;
      e.acceptCyc  = cyc;
      sbQ.push_back(e);
      @(posedge clk);
      #1;
      if (!hold) req_valid = 1'b0;
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 40 && sbQ.size() != 0; i++) @(negedge clk);
      @(negedge clk);
      #1;
      if (sbQ.size() != 0) begin
         checkOutput("drainTimeout", sbQ.size(), 32'd0);
         sbQ.delete();
      end
   endtask

   // Single load on the aligning instance with a bounded wait for its reply.
   task automatic runAlignLoad(input string tag, input logic [1:0] sz,
                               input logic [31:0] addr, input logic [31:0] expData);
      int acc;
      bit seen = 1'b0;
      @(negedge clk);
      reqValid2 = 1'b1;
      reqSize2  = sz;
      reqAddr2  = addr;
      acc       = cyc;
      @(posedge clk);
      #1;
      reqValid2 = 1'b0;
      checkOutput({tag, "Addr"}, dmAddr2, {addr[31:2], 2'b00});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (respValid2) begin
            seen = 1'b1;
            checkOutput({tag, "Data"}, respRdata2, expData);
            checkOutput({tag, "Err"}, {31'd0, respErr2}, 32'd0);
            checkOutput({tag, "Lat"}, cyc - acc, 32'd2);
            checkOutput({tag, "NoWrite"}, {31'd0, memWrite2}, 32'd0);
            break;
         end
      end
      if (!seen) checkOutput({tag, "RespTimeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int savedPulses;
      rst_lsu      = 1'b1;
      preload      = 1'b1;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      reqValid2    = 1'b0;
      reqSize2     = 2'b00;
      reqAddr2     = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_lsu = 1'b0;
      preload = 1'b0;

      @(negedge clk);
      checkOutput("rstReady", {31'd0, req_ready}, 32'd1);
      checkOutput("rstRespValid", {31'd0, resp_valid}, 32'd0);
      checkOutput("rstRdata", resp_rdata, 32'd0);
      checkOutput("rstErr", {31'd0, resp_err}, 32'd0);
      checkOutput("rstDmAddr", dm_addr, 32'd0);
      checkOutput("rstDmWdata", dm_write_data, 32'd0);
      checkOutput("rstEnables", {30'd0, ctrl_dataMem_Write, ctrl_dataMem2reg}, 32'd0);

      applyStimulus("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1'b0);
      checkOutput("swDmAddr", dm_addr, 32'h10);
      checkOutput("swWe", {31'd0, ctrl_dataMem_Write}, 32'd1);
      checkOutput("swDmData", dm_write_data, 32'hDEADBEEF);
      applyStimulus("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, 1'b0);

      applyStimulus("lb20",  1'b0, 2'b00, 1'b0, 32'h20, 32'd0, 32'hFFFF_FF80, 1'b0, 2, 1'b0);
      applyStimulus("lbu20", 1'b0, 2'b00, 1'b1, 32'h20, 32'd0, 32'h0000_0080, 1'b0, 2, 1'b0);
      applyStimulus("lb22",  1'b0, 2'b00, 1'b0, 32'h22, 32'd0, 32'h0000_007F, 1'b0, 2, 1'b0);
      applyStimulus("lb23",  1'b0, 2'b00, 1'b0, 32'h23, 32'd0, 32'h0000_0001, 1'b0, 2, 1'b0);
      applyStimulus("lh22",  1'b0, 2'b01, 1'b0, 32'h22, 32'd0, 32'h0000_7F01, 1'b0, 2, 1'b0);
      applyStimulus("lh20",  1'b0, 2'b01, 1'b0, 32'h20, 32'd0, 32'hFFFF_80FF, 1'b0, 2, 1'b0);
      applyStimulus("lhu20", 1'b0, 2'b01, 1'b1, 32'h20, 32'd0, 32'h0000_80FF, 1'b0, 2, 1'b0);

      applyStimulus("sb31", 1'b1, 2'b00, 1'b0, 32'h31, 32'h1234_56AA, 32'd0, 1'b0, 3, 1'b0);
      applyStimulus("lw30a", 1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 32'h11AA_3344, 1'b0, 2, 1'b0);
      applyStimulus("sh32", 1'b1, 2'b01, 1'b0, 32'h32, 32'h1234_BEEF, 32'd0, 1'b0, 3, 1'b0);
      applyStimulus("lw30b", 1'b0, 2'b10, 1'b0, 32'h30, 32'd0, 32'h11AA_BEEF, 1'b0, 2, 1'b0);
      waitDrain();

      savedPulses = wrPulses + rdPulses;
      applyStimulus("lw42",  1'b0, 2'b10, 1'b0, 32'h42, 32'd0, 32'd0, 1'b1, 1, 1'b0);
      applyStimulus("ill",   1'b0, 2'b11, 1'b0, 32'h20, 32'd0, 32'd0, 1'b1, 1, 1'b0);
      applyStimulus("lh21",  1'b0, 2'b01, 1'b0, 32'h21, 32'd0, 32'd0, 1'b1, 1, 1'b0);
      applyStimulus("sw12",  1'b1, 2'b10, 1'b0, 32'h12, 32'h0BAD_0BAD, 32'd0, 1'b1, 1, 1'b0);
      waitDrain();
      checkOutput("errNoMemCycles", wrPulses + rdPulses - savedPulses, 32'd0);
      checkOutput("errMemIntact", mem[4], 32'hDEADBEEF);

      applyStimulus("hs0", 1'b1, 2'b10, 1'b0, 32'h60, 32'hA0A0_A0A0, 32'd0, 1'b0, 2, 1'b1);
      applyStimulus("hs1", 1'b1, 2'b00, 1'b0, 32'h61, 32'h0000_00B1, 32'd0, 1'b0, 3, 1'b1);
      applyStimulus("hs2", 1'b1, 2'b01, 1'b0, 32'h62, 32'h0000_C2C2, 32'd0, 1'b0, 3, 1'b1);
      req_valid = 1'b0;
      waitDrain();
      checkOutput("hsMemWord", mem[24], 32'hA0B1_C2C2);

      runAlignLoad("alignLw42", 2'b10, 32'h42, 32'hCAFE_F00D);
      runAlignLoad("alignLh23", 2'b01, 32'h23, 32'h0000_7F01);

      // Reset lands in the WR cycle of a byte store.
      @(negedge clk);
      req_valid = 1'b1;
      req_write = 1'b1;
      req_size  = 2'b00;
      req_addr  = 32'h51;
      req_wdata = 32'h0000_00AA;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("rmwRead", {31'd0, ctrl_dataMem2reg}, 32'd1);
      @(negedge clk);
      checkOutput("rmwWriteBeforeRst", {31'd0, ctrl_dataMem_Write}, 32'd1);
      rst_lsu   = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h50;
      req_size  = 2'b10;
      #1;
      checkOutput("rstGatesWrite", {31'd0, ctrl_dataMem_Write}, 32'd0);
      @(posedge clk);
      #1;
      rst_lsu   = 1'b0;
      req_valid = 1'b0;
      @(negedge clk);
      checkOutput("postRstReady", {31'd0, req_ready}, 32'd1);
      checkOutput("postRstRespValid", {31'd0, resp_valid}, 32'd0);
      checkOutput("postRstMem", mem[20], 32'h5566_7788);
      repeat (4) @(negedge clk);
      checkOutput("postRstQueue", sbQ.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit: the initiator side of the word-only data memory port.
- Accepts one load/store request at a time from the core and turns it into memory cycles: single word accesses, or read-modify-write for sub-word stores.
- Returns an aligned, extended load result with a single-cycle response pulse.
- Sits between the core datapath (address from ALU result, store data from rt) and the dataMemory block.

Parameters:
- ERR_ON_MISALIGN, 1, 1: misaligned half/word requests are reported as errors with no memory access; 0: the low address bits are forced to alignment and the access proceeds.
- BIG_ENDIAN, 1, 1: byte offset 0 maps to bits [31:24]; 0: byte offset 0 maps to bits [7:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst_lsu  in  1  reset; synchronous, active-high.
- req_valid  in  1  core request present.
- req_ready  out  1  high only in IDLE; a request is accepted on a cycle where req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  zero-extend the load result (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the value is taken from the low bits.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result; valid while resp_valid is high; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal size; valid while resp_valid is high.
- dm_addr  out  32  word-aligned address: {addr_q[31:2], 2'b00}; 0 when idle.
- dm_write_data  out  32  word to write.
- ctrl_dataMem_Write  out  1  memory write enable.
- ctrl_dataMem2reg  out  1  memory read enable.
- dm_read_data  in  32  combinational read data from the memory.

Behaviour:
- States: IDLE, RD, RMW_RD, WR, RESP.
- Accepted request: addr, size, unsigned flag and wdata are latched into *_q registers.
- Transitions out of IDLE on accept (T = accept cycle):
  - Error (size 11, or ERR_ON_MISALIGN=1 with half && addr[0], or word && addr[1:0] != 0) -> RESP. resp_valid at T+1, resp_err=1, rdata=0.
  - Load -> RD.
  - Word store -> WR.
  - Byte or half store -> RMW_RD.
- RD: ctrl_dataMem2reg=1; dm_read_data latched into rword_q; -> RESP. Load latency: resp_valid at T+2.
- RMW_RD: ctrl_dataMem2reg=1; the word is latched; -> WR.
- WR: ctrl_dataMem_Write=1 with dm_write_data:
  - Word store: wdata_q.
  - Half store: the latched word with the addressed half replaced by wdata_q[15:0].
  - Byte store: the latched word with the addressed lane replaced by wdata_q[7:0].
  - Then -> RESP. Latency: word store resp at T+2, sub-word store resp at T+3.
- RESP: resp_valid=1 for exactly one cycle; -> IDLE. req_ready returns high the following cycle; back-to-back requests therefore have at least 1 idle cycle between them.
- Lane select (BIG_ENDIAN=1):
  - Byte: offset 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Half: addr[1]=0 -> [31:16], addr[1]=1 -> [15:0].
  - BIG_ENDIAN=0 mirrors this mapping.
- Load extension: sign-extend from bit 7/15 unless req_unsigned=1, in which case zero-extend. Word loads are passed through unchanged.
- ERR_ON_MISALIGN=0: addr_q[1:0] is cleared for words and addr_q[0] for halves; no error is raised.
- Outside RD/RMW_RD/WR, all dm_* outputs and both ctrl enables are 0.
- req_valid while not IDLE is ignored; request inputs may change freely then.
- Reset:
  - Every state register returns to IDLE and all *_q registers clear to 0 on the edge where rst_lsu=1.
  - After reset: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all dm outputs 0.
  - ctrl_dataMem_Write is gated by !rst_lsu, so reset asserted during WR performs no write. A reset mid-RMW therefore leaves memory unchanged.
  - A request presented in the reset cycle is not accepted.
- Address bits above [9:2] pass through unchanged; wrap-around is the memory's concern.

Test Plan:
- Word store then load: sw 0xDEADBEEF at addr 0x10 (T=0) -> WR at T=1 with dm_addr=0x10. Then lw 0x10 -> resp_valid 2 cycles after accept, rdata=0xDEADBEEF, err=0.
- Byte loads: memory word 0x80FF7F01 at 0x20. lb 0x20 -> 0xFFFFFF80; lbu 0x20 -> 0x00000080; lb 0x22 -> 0x0000007F; lh 0x22 -> 0x00007F01.
- Sub-word store RMW: memory word 0x11223344 at 0x30. sb 0xAA to 0x31 -> RMW_RD, then WR writes 0x11AA3344, resp at T+3. Then sh 0xBEEF to 0x32 -> 0x11AABEEF.
- Misalign/illegal:
  - lw at 0x42 -> resp at T+1, err=1, rdata=0, no ctrl enable pulses.
  - size=11 -> err=1.
  - With ERR_ON_MISALIGN=0, lw 0x42 reads word 0x40 with err=0.
- Handshake: req_valid held high continuously with 3 stores -> each accepted only when req_ready=1; exactly one resp_valid pulse per request, in order.
- Reset during WR of an sb -> no write pulse in the reset cycle, memory word unchanged. Next cycle: req_ready=1, resp_valid=0.
